// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with write-through bypass,
// optional hardwired-zero register 0, a pending-write scoreboard for
// multicycle results, and a sequential soft-clear sweep engine.
// Optional debug access ports are compiled in with `define REGFILE_DEBUG_EN.
module regfile_scoreboard #(
  parameter int NB_DATA  = 32,
  parameter int NB_ADDR  = 5,
  parameter int N_READ   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [N_READ*NB_ADDR-1:0]   i_raddr,
  output logic [N_READ*NB_DATA-1:0]   o_rdata,
  output logic [N_READ-1:0]           o_rpend,
  input  logic                        i_we0,
  input  logic [NB_ADDR-1:0]          i_waddr0,
  input  logic [NB_DATA-1:0]          i_wdata0,
  input  logic                        i_we1,
  input  logic [NB_ADDR-1:0]          i_waddr1,
  input  logic [NB_DATA-1:0]          i_wdata1,
  input  logic                        i_issue,
  input  logic [NB_ADDR-1:0]          i_issue_rd,
  input  logic                        i_clear,
`ifdef REGFILE_DEBUG_EN
  input  logic [NB_ADDR-1:0]          i_dbg_addr,
  output logic [NB_DATA-1:0]          o_dbg_data,
  output logic [(2**NB_ADDR)-1:0]     o_dbg_pend,
`endif
  output logic                        o_busy
);

  localparam int DEPTH = 2**NB_ADDR;
  localparam logic [NB_ADDR-1:0] LAST_ADDR = {NB_ADDR{1'b1}};
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t               state;
  logic [NB_ADDR-1:0]   sweep_cnt;
  logic [NB_DATA-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]     pend;

  logic                 we0_ok;
  logic                 we1_ok;
  logic                 issue_ok;
  logic                 clear_start;
  logic [DEPTH-1:0]     clr_mask;
  logic [DEPTH-1:0]     set_mask;

  logic [NB_ADDR-1:0]   rd_addr [N_READ];
  logic [NB_DATA-1:0]   rd_data [N_READ];
  logic                 rd_hit0 [N_READ];
  logic                 rd_hit1 [N_READ];

  // Qualify write/issue requests: everything is frozen while sweeping, and
  // register 0 can never be written or marked pending when hardwired to zero.
  always_comb begin
    we0_ok      = i_we0 && !o_busy && !(HAS_ZERO && (i_waddr0 == '0));
    we1_ok      = i_we1 && !o_busy && !(HAS_ZERO && (i_waddr1 == '0));
    issue_ok    = i_issue && !o_busy && !(HAS_ZERO && (i_issue_rd == '0));
    clear_start = i_clear && (state == IDLE);
  end

  // Scoreboard update masks: retiring writes clear, issues set (set wins).
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (we0_ok) clr_mask[i_waddr0] = 1'b1;
    if (we1_ok) clr_mask[i_waddr1] = 1'b1;
    if (issue_ok) set_mask[i_issue_rd] = 1'b1;
  end

  // Clear sweep controller: walks the counter from 0 to DEPTH-1 once per
  // i_clear; the exit test happens on the last address before the wrap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      sweep_cnt <= '0;
      o_busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_clear) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
            o_busy    <= 1'b1;
          end
        end
        SWEEP: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_ADDR) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Register storage: sweep zeroes one entry per cycle, otherwise the two
  // write ports commit, with port 1 landing last so it wins on a collision.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (state == SWEEP) begin
      regs[sweep_cnt] <= '0;
    end else begin
      if (we0_ok) regs[i_waddr0] <= i_wdata0;
      if (we1_ok) regs[i_waddr1] <= i_wdata1;
    end
  end

  // Pending bits: wiped when a sweep starts, otherwise cleared by retiring
  // writes and set by new issues.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pend <= '0;
    end else if (clear_start) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr_mask) | set_mask;
    end
  end

  // Read ports: hardwired zero first, then write-through bypass from port 1
  // and port 0, then the stored value; the pending flag is hidden when the
  // bypass is already supplying the fresh value.
  always_comb begin
    o_rdata = '0;
    o_rpend = '0;
    for (int k = 0; k < N_READ; k++) begin
      rd_addr[k] = i_raddr[k*NB_ADDR +: NB_ADDR];
      rd_hit1[k] = we1_ok && (i_waddr1 == rd_addr[k]);
      rd_hit0[k] = we0_ok && (i_waddr0 == rd_addr[k]);
      if (HAS_ZERO && (rd_addr[k] == '0)) begin
        rd_data[k] = '0;
      end else if (rd_hit1[k]) begin
        rd_data[k] = i_wdata1;
      end else if (rd_hit0[k]) begin
        rd_data[k] = i_wdata0;
      end else begin
        rd_data[k] = regs[rd_addr[k]];
      end
      o_rdata[k*NB_DATA +: NB_DATA] = rd_data[k];
      o_rpend[k] = pend[rd_addr[k]] && !rd_hit0[k] && !rd_hit1[k];
    end
  end

`ifdef REGFILE_DEBUG_EN
  // Debug view of raw state for the UART dump unit, no bypass applied.
  always_comb begin
    o_dbg_data = regs[i_dbg_addr];
    o_dbg_pend = pend;
  end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: table-driven vectors through a scoreboard queue,
// plus hand-written sequences for the clear sweep and reset-abort cases.
module tb_regfile_scoreboard;

  logic        clk;
  logic        reset;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rpend;
  logic        we0;
  logic [4:0]  waddr0;
  logic [31:0] wdata0;
  logic        we1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1;
  logic        issue;
  logic [4:0]  issue_rd;
  logic        clear;
  logic        busy;
`ifdef REGFILE_DEBUG_EN
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] dbg_pend;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iss;
    logic [4:0]  ird;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  ep;
  } vec_t;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  p;
  } exp_t;

  vec_t vecs [16];
  exp_t sbq [$];

  regfile_scoreboard #(
    .NB_DATA(32), .NB_ADDR(5), .N_READ(2), .ZERO_REG(1)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_raddr(raddr),
    .o_rdata(rdata),
    .o_rpend(rpend),
    .i_we0(we0),
    .i_waddr0(waddr0),
    .i_wdata0(wdata0),
    .i_we1(we1),
    .i_waddr1(waddr1),
    .i_wdata1(wdata1),
    .i_issue(issue),
    .i_issue_rd(issue_rd),
    .i_clear(clear),
`ifdef REGFILE_DEBUG_EN
    .i_dbg_addr(dbg_addr),
    .o_dbg_data(dbg_data),
    .o_dbg_pend(dbg_pend),
`endif
    .o_busy(busy)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck DUT can never hang the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkv(input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic is, input logic [4:0] rd,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [1:0] ep);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1;
    v.we0 = w0;  v.wa0 = a0; v.wd0 = d0;
    v.we1 = w1;  v.wa1 = a1; v.wd1 = d1;
    v.iss = is;  v.ird = rd;
    v.e0 = e0;   v.e1 = e1;  v.ep = ep;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic driveIdle();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    issue = 1'b0; issue_rd = '0;
    clear = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    raddr  = {v.ra1, v.ra0};
    we0    = v.we0; waddr0 = v.wa0; wdata0 = v.wd0;
    we1    = v.we1; waddr1 = v.wa1; wdata1 = v.wd1;
    issue  = v.iss; issue_rd = v.ird;
  endtask

  task automatic readCheck(input string name, input logic [4:0] a0, input logic [4:0] a1,
                           input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] ep);
    raddr = {a1, a0};
    #1;
    checkOutput({name, "_d0"}, {32'd0, rdata[31:0]}, {32'd0, e0});
    checkOutput({name, "_d1"}, {32'd0, rdata[63:32]}, {32'd0, e1});
    checkOutput({name, "_pend"}, {62'd0, rpend}, {62'd0, ep});
  endtask

  task automatic countBusy(output int cycles, input int limit);
    cycles = 0;
    while (busy === 1'b1 && cycles < limit) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int   cycles;
    exp_t e;

    // Vector table: one row per cycle, writes commit at the end of the row.
    vecs[0]  = mkv(5'd3, 5'd31, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        32'h0,        2'b00);
    vecs[1]  = mkv(5'd5, 5'd5,  1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 32'h12345678, 0, 5'd0,  32'h12345678, 32'h12345678, 2'b00);
    vecs[2]  = mkv(5'd5, 5'd0,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0,  32'h12345678, 32'h0,        2'b00);
    vecs[3]  = mkv(5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 5'd0, 32'hFFFFFFFF, 1, 5'd0,  32'h0,        32'h0,        2'b00);
    vecs[4]  = mkv(5'd0, 5'd5,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        32'h12345678, 2'b00);
    vecs[5]  = mkv(5'd7, 5'd5,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd7,  32'h0,        32'h12345678, 2'b00);
    vecs[6]  = mkv(5'd7, 5'd7,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        32'h0,        2'b11);
    vecs[7]  = mkv(5'd7, 5'd5,  1, 5'd7, 32'h55,       0, 5'd0, 32'h0,        0, 5'd0,  32'h55,       32'h12345678, 2'b00);
    vecs[8]  = mkv(5'd7, 5'd7,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0,  32'h55,       32'h55,       2'b00);
    vecs[9]  = mkv(5'd7, 5'd3,  1, 5'd7, 32'h66,       0, 5'd0, 32'h0,        1, 5'd7,  32'h66,       32'h0,        2'b00);
    vecs[10] = mkv(5'd7, 5'd7,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0,  32'h66,       32'h66,       2'b11);
    vecs[11] = mkv(5'd9, 5'd10, 1, 5'd9, 32'hA,        1, 5'd10, 32'hB,       1, 5'd12, 32'hA,        32'hB,        2'b00);
    vecs[12] = mkv(5'd12, 5'd7, 0, 5'd0, 32'h0,        1, 5'd7, 32'h77,       0, 5'd0,  32'h0,        32'h77,       2'b01);
    vecs[13] = mkv(5'd7, 5'd12, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0,  32'h77,       32'h0,        2'b10);
    vecs[14] = mkv(5'd9, 5'd10, 1, 5'd12, 32'h1212,    0, 5'd0, 32'h0,        0, 5'd0,  32'hA,        32'hB,        2'b00);
    vecs[15] = mkv(5'd12, 5'd12, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,        0, 5'd0,  32'h1212,     32'h1212,     2'b00);

    reset = 1'b1;
    raddr = '0;
    driveIdle();
`ifdef REGFILE_DEBUG_EN
    dbg_addr = '0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Table-driven pass through the scoreboard queue.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      e.d0 = vecs[i].e0;
      e.d1 = vecs[i].e1;
      e.p  = vecs[i].ep;
      sbq.push_back(e);
      #1;
      e = sbq.pop_front();
      checkOutput($sformatf("vec%0d_d0", i), {32'd0, rdata[31:0]}, {32'd0, e.d0});
      checkOutput($sformatf("vec%0d_d1", i), {32'd0, rdata[63:32]}, {32'd0, e.d1});
      checkOutput($sformatf("vec%0d_pend", i), {62'd0, rpend}, {62'd0, e.p});
      checkOutput($sformatf("vec%0d_busy", i), {63'd0, busy}, 64'd0);
    end

    // Fill every register with a distinct nonzero pattern.
    for (int i = 1; i < 32; i += 2) begin
      @(negedge clk);
      we0 = 1'b1; waddr0 = 5'(i);     wdata0 = 32'h01010101 * i;
      we1 = 1'b1; waddr1 = 5'(i + 1); wdata1 = 32'h01010101 * (i + 1);
    end
    @(negedge clk);
    driveIdle();
    issue = 1'b1; issue_rd = 5'd20;
    @(negedge clk);
    driveIdle();
    readCheck("fill_20_31", 5'd20, 5'd31, 32'h14141414, 32'h1F1F1F1F, 2'b01);

    // Clear sweep with blocked writes and issues during the busy window.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("sweep_busy_rise", {63'd0, busy}, 64'd1);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      we0 = 1'b1; waddr0 = 5'd4;  wdata0 = 32'hBAD0BAD0;
      we1 = 1'b1; waddr1 = 5'd25; wdata1 = 32'hBAD1BAD1;
      issue = 1'b1; issue_rd = 5'd8;
      raddr = {5'd8, 5'd25};
      if (cycles == 0) begin
        #1;
        checkOutput("sweep_no_bypass", {32'd0, rdata[31:0]}, {32'd0, 32'h19191919});
        checkOutput("sweep_no_pend", {62'd0, rpend}, 64'd0);
      end
      cycles++;
      @(negedge clk);
    end
    driveIdle();
    checkOutput("sweep_len", 64'(cycles), 64'd32);
    for (int a = 0; a < 32; a += 2) begin
      readCheck($sformatf("post_sweep_%0d", a), 5'(a), 5'(a + 1), 32'h0, 32'h0, 2'b00);
    end

    // Reset in the middle of a sweep aborts it at once.
    @(negedge clk);
    we0 = 1'b1; waddr0 = 5'd3;  wdata0 = 32'h33;
    we1 = 1'b1; waddr1 = 5'd31; wdata1 = 32'h3131;
    @(negedge clk);
    driveIdle();
    readCheck("pre_abort", 5'd3, 5'd31, 32'h33, 32'h3131, 2'b00);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    countBusy(cycles, 10);
    checkOutput("abort_reach10", 64'(cycles), 64'd10);
    reset = 1'b1;
    #1;
    checkOutput("abort_busy_drop", {63'd0, busy}, 64'd0);
    readCheck("abort_regs", 5'd3, 5'd31, 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    countBusy(cycles, 100);
    checkOutput("resweep_len", 64'(cycles), 64'd32);
    readCheck("resweep_idle", 5'd31, 5'd5, 32'h0, 32'h0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
